// File: rtl/keypad_pkg.sv
// keypad_pkg: register map, field positions, scanner states and AXI response codes shared by the keypad slave
package keypad_pkg;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_DIV     = 2'd1;
  localparam logic [1:0] REG_KEY     = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;
  localparam int CTRL_SCAN_EN = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int KEY_VALID    = 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_HOLD} scan_state_e;
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: divided scan tick, column synchronizer and row-scan FSM producing a one-cycle capture pulse
module keypad_scanner
  import keypad_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scan_en_i,
  input  logic [15:0] scan_div_i,
  input  logic [3:0]  key_col_i,
  output logic [3:0]  key_row_o,
  output logic        cap_o,
  output logic [3:0]  code_o
);
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] col_s1_q, col_s2_q;
  logic [1:0] row_q, row_d, col_idx;
  scan_state_e state_q, state_d;
  logic tick, pressed;
  always_comb begin
    tick = scan_en_i && cnt_q == scan_div_i;
    cnt_d = (!scan_en_i || tick) ? '0 : cnt_q + 16'd1;
    pressed = col_s2_q != 4'hF;
    col_idx = !col_s2_q[0] ? 2'd0 : !col_s2_q[1] ? 2'd1 : !col_s2_q[2] ? 2'd2 : 2'd3;
    state_d = state_q;
    row_d = row_q;
    cap_o = 1'b0;
    if (!scan_en_i) begin
      state_d = ST_IDLE;
      row_d = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_SCAN;
    end else if (tick) begin
      if (!pressed) begin
        row_d = row_q + 2'd1;
        state_d = ST_SCAN;
      end else if (state_q == ST_SCAN) begin
        cap_o = 1'b1;
        state_d = ST_HOLD;
      end
    end
    code_o = {row_q, col_idx};
    key_row_o = state_q == ST_IDLE ? 4'hF : ~(4'b0001 << row_q);
  end
  // Columns idle high, so the synchronizer resets to "no key"
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      row_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      cnt_q <= cnt_d;
      col_s1_q <= key_col_i;
      col_s2_q <= col_s1_q;
      row_q <= row_d;
      state_q <= state_d;
    end
  end
endmodule

// File: rtl/keypad_axil_slave.sv
// keypad_axil_slave: AXI4-Lite register slave (CTRL, SCAN_DIV, KEY, SCRATCH) around the keypad scanner
module keypad_axil_slave
  import keypad_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [15:0] SCAN_DIV_RST = 16'd1000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [3:0]                      key_row,
  input  logic [3:0]                      key_col,
  output logic                            irq
);
  logic awready_q, awready_d, bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d, scratch_q, scratch_d, wmask, rd_word;
  logic [1:0] ctrl_q, ctrl_d, wsel, rsel;
  logic [15:0] div_q, div_d;
  logic [3:0] code_q, code_d, cap_code;
  logic valid_q, valid_d, wr_en, rd_en, w1c, cap;
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  keypad_scanner u_scan (
    .clk_i(ACLK), .rst_i(ARESET), .scan_en_i(ctrl_q[CTRL_SCAN_EN]), .scan_div_i(div_q),
    .key_col_i(key_col), .key_row_o(key_row), .cap_o(cap), .code_o(cap_code)
  );
  // Ready flags self-clear so each handshake lasts exactly one cycle
  always_comb begin
    wsel = S_AXI_AWADDR[3:2];
    rsel = S_AXI_ARADDR[3:2];
    wr_en = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    rd_en = arready_q & S_AXI_ARVALID;
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    bvalid_d = wr_en | (bvalid_q & ~S_AXI_BREADY);
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d = rd_en | (rvalid_q & ~S_AXI_RREADY);
    rd_word = rsel == REG_CTRL ? {30'd0, ctrl_q} :
              rsel == REG_DIV  ? {16'd0, div_q} :
              rsel == REG_KEY  ? {23'd0, valid_q, 4'd0, code_q} : scratch_q;
    rdata_d = rd_en ? rd_word : rdata_q;
    wmask = strb_mask(S_AXI_WSTRB);
    ctrl_d = (wr_en && wsel == REG_CTRL) ? (ctrl_q & ~wmask[1:0]) | (S_AXI_WDATA[1:0] & wmask[1:0]) : ctrl_q;
    div_d = (wr_en && wsel == REG_DIV) ? (div_q & ~wmask[15:0]) | (S_AXI_WDATA[15:0] & wmask[15:0]) : div_q;
    scratch_d = (wr_en && wsel == REG_SCRATCH) ? (scratch_q & ~wmask) | (S_AXI_WDATA & wmask) : scratch_q;
    w1c = wr_en && wsel == REG_KEY && S_AXI_WSTRB[1] && S_AXI_WDATA[KEY_VALID];
    valid_d = cap | (valid_q & ~w1c);
    code_d = cap ? cap_code : code_q;
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      bvalid_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      ctrl_q <= '0;
      div_q <= SCAN_DIV_RST;
      code_q <= '0;
      valid_q <= 1'b0;
      scratch_q <= '0;
    end else begin
      awready_q <= awready_d;
      bvalid_q <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      ctrl_q <= ctrl_d;
      div_q <= div_d;
      code_q <= code_d;
      valid_q <= valid_d;
      scratch_q <= scratch_d;
    end
  end
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY = awready_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = RESP_OKAY;
  assign irq = valid_q & ctrl_q[CTRL_IRQ_EN];
endmodule
